// File: rtl/hsv_core_issue_dispatch.sv
// hsv_core_issue_dispatch: issue-stage dispatcher with per-register pending-write scoreboard and per-slot handshakes
module hsv_core_issue_dispatch #(
  parameter int NUM_UNITS = 5,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 2,
  parameter int TOKEN_W   = 4
) (
  input  logic                           clk_core,
  input  logic                           rst_core,
  input  logic                           flush_req,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_UNITS-1:0]           in_select,
  input  logic [PAYLOAD_W-1:0]           in_payload,
  input  logic [REG_AW-1:0]              in_rs1_addr,
  input  logic [REG_AW-1:0]              in_rs2_addr,
  input  logic [NUM_REGS-1:0]            in_rs_mask,
  input  logic [REG_AW-1:0]              in_rd_addr,
  input  logic                           in_rd_we,
  output logic [REG_AW-1:0]              rf_rs1_addr,
  output logic [REG_AW-1:0]              rf_rs2_addr,
  input  logic [31:0]                    rf_rs1_data,
  input  logic [31:0]                    rf_rs2_data,
  input  logic [NUM_REGS-1:0]            commit_mask,
  output logic [NUM_UNITS-1:0]           out_valid,
  input  logic [NUM_UNITS-1:0]           out_ready,
  output logic [NUM_UNITS*PAYLOAD_W-1:0] out_payload,
  output logic [NUM_UNITS*32-1:0]        out_rs1,
  output logic [NUM_UNITS*32-1:0]        out_rs2,
  output logic [NUM_UNITS*TOKEN_W-1:0]   out_token,
  output logic                           hazard
);
  logic [CNT_W-1:0]   cnt [NUM_REGS];
  logic [TOKEN_W-1:0] token;
  logic [NUM_REGS-1:0] inc, dec;
  logic sel_ok, slot_free, rd_full, accept;
  assign rf_rs1_addr = in_rs1_addr;
  assign rf_rs2_addr = in_rs2_addr;
  // cnt[0] stays 0 after reset because inc/dec can never fire for it
  always_comb begin
    hazard = 1'b0;
    inc = '0;
    dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      hazard = hazard | (in_rs_mask[r] & (cnt[r] != '0));
      inc[r] = accept & in_rd_we & (in_rd_addr != '0) & (in_rd_addr == REG_AW'(r));
      dec[r] = commit_mask[r] & (cnt[r] != '0);
    end
  end
  assign rd_full   = in_rd_we & (in_rd_addr != '0) & (cnt[in_rd_addr] == '1);
  assign sel_ok    = (in_select != '0) && ((in_select & (in_select - 1'b1)) == '0);
  assign slot_free = |(in_select & (~out_valid | out_ready));
  assign in_ready  = ~flush_req & ~rst_core & sel_ok & ~hazard & ~rd_full & slot_free;
  assign accept    = in_valid & in_ready;
  always_ff @(posedge clk_core) begin
    if (rst_core || flush_req) begin
      out_valid <= '0;
      token <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (accept && in_select[u]) begin
          out_valid[u] <= 1'b1;
          out_payload[u*PAYLOAD_W +: PAYLOAD_W] <= in_payload;
          out_rs1[u*32 +: 32] <= rf_rs1_data;
          out_rs2[u*32 +: 32] <= rf_rs2_data;
          out_token[u*TOKEN_W +: TOKEN_W] <= token;
        end else if (out_ready[u]) begin
          out_valid[u] <= 1'b0;
        end
      end
      if (accept) token <= token + 1'b1;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r]) cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hsv_core_issue_dispatch.sv
// tb_hsv_core_issue_dispatch: vector table plus per-slot scoreboard queues for the issue dispatcher
module tb_hsv_core_issue_dispatch;
  logic clk_core = 1'b0;
  logic rst_core, flush_req, in_valid, in_ready, in_rd_we, hazard;
  logic [4:0] in_select, in_rs1_addr, in_rs2_addr, in_rd_addr, rf_rs1_addr, rf_rs2_addr;
  logic [4:0] out_valid, out_ready;
  logic [63:0] in_payload;
  logic [31:0] in_rs_mask, commit_mask, rf_rs1_data, rf_rs2_data;
  logic [5*64-1:0] out_payload;
  logic [5*32-1:0] out_rs1, out_rs2;
  logic [5*4-1:0] out_token;

  hsv_core_issue_dispatch dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select),
    .in_payload(in_payload), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs_mask(in_rs_mask), .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .commit_mask(commit_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_token(out_token), .hazard(hazard)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic valid; logic [4:0] sel; logic [4:0] rs1; logic [31:0] mask;
    logic [4:0] rd; logic we; logic [31:0] commit; logic [4:0] ordy; logic flush;
    logic [15:0] pay; logic [15:0] d1; logic [15:0] d2; logic er; logic eh;
  } vec_t;
  typedef struct { logic [63:0] pay; logic [31:0] d1; logic [31:0] d2; logic [3:0] tok; } slot_t;

  slot_t q [5][$];
  logic [3:0] tok_model = '0;
  int errors = 0, checks = 0;
  vec_t tbl [31];

  function automatic vec_t mk(logic v, logic [4:0] s, logic [4:0] r1, logic [31:0] m, logic [4:0] rd,
                              logic we, logic [31:0] c, logic [4:0] o, logic [15:0] p, logic er, logic eh);
    vec_t t;
    t.valid = v; t.sel = s; t.rs1 = r1; t.mask = m; t.rd = rd; t.we = we; t.commit = c;
    t.ordy = o; t.flush = 1'b0; t.pay = p; t.d1 = ~p; t.d2 = p ^ 16'h5A5A; t.er = er; t.eh = eh;
    return t;
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, exp);
    end
  endtask

  task automatic run(vec_t t, string n);
    int s;
    slot_t e;
    in_valid = t.valid; in_select = t.sel; in_rs1_addr = t.rs1; in_rs2_addr = t.rs1 + 5'd1;
    in_rs_mask = t.mask; in_rd_addr = t.rd; in_rd_we = t.we; commit_mask = t.commit;
    out_ready = t.ordy; flush_req = t.flush; in_payload = {48'h0, t.pay};
    rf_rs1_data = {16'h0, t.d1}; rf_rs2_data = {16'h0, t.d2};
    @(negedge clk_core);
    chk({n, " in_ready"}, 64'(in_ready), 64'(t.er));
    chk({n, " hazard"}, 64'(hazard), 64'(t.eh));
    chk({n, " rf_addr"}, 64'({rf_rs1_addr, rf_rs2_addr}), 64'({t.rs1, t.rs1 + 5'd1}));
    if (!$onehot(in_select) && in_ready) begin
      checks++; errors++;
      $display("FAIL %s select_guard: in_ready=1 with select %b", n, in_select);
    end
    for (int u = 0; u < 5; u++) begin
      chk($sformatf("%s out_valid[%0d]", n, u), 64'(out_valid[u]), 64'(q[u].size() != 0));
      if (out_valid[u] && q[u].size() != 0) begin
        e = q[u][0];
        chk($sformatf("%s slot%0d payload", n, u), out_payload[u*64 +: 64], e.pay);
        chk($sformatf("%s slot%0d rs1", n, u), 64'(out_rs1[u*32 +: 32]), 64'(e.d1));
        chk($sformatf("%s slot%0d rs2", n, u), 64'(out_rs2[u*32 +: 32]), 64'(e.d2));
        chk($sformatf("%s slot%0d token", n, u), 64'(out_token[u*4 +: 4]), 64'(e.tok));
        if (out_ready[u]) void'(q[u].pop_front());
      end
    end
    if (t.flush) begin
      for (int u = 0; u < 5; u++) q[u].delete();
      tok_model = '0;
    end else if (t.valid && t.er) begin
      s = 0;
      for (int u = 0; u < 5; u++) if (t.sel[u]) s = u;
      e.pay = {48'h0, t.pay}; e.d1 = {16'h0, t.d1}; e.d2 = {16'h0, t.d2}; e.tok = tok_model;
      q[s].push_back(e);
      tok_model = tok_model + 4'd1;
    end
    @(posedge clk_core);
    #1;
  endtask

  localparam logic [31:0] B5 = 32'h20, B7 = 32'h80;
  localparam logic [4:0] ALL = 5'h1F;

  initial begin
    vec_t t;
    tbl[0]  = mk(1, 5'b00100, 0, 0, 5, 1, 0, ALL, 16'hABCD, 1, 0);
    tbl[0].d1 = 16'h11; tbl[0].d2 = 16'h22;
    tbl[1]  = mk(1, 5'b00010, 5, B5, 0, 0, B5, ALL, 16'd2, 0, 1);
    tbl[2]  = mk(1, 5'b00010, 5, B5, 0, 0, 0, ALL, 16'd2, 1, 0);
    tbl[3]  = mk(1, 5'b00001, 1, 0, 7, 1, 0, ALL, 16'd3, 1, 0);
    tbl[4]  = mk(1, 5'b00010, 1, 0, 7, 1, 0, ALL, 16'd4, 1, 0);
    tbl[5]  = mk(1, 5'b01000, 1, 0, 7, 1, 0, ALL, 16'd5, 1, 0);
    tbl[6]  = mk(1, 5'b10000, 1, 0, 7, 1, 0, ALL, 16'd6, 0, 0);
    tbl[7]  = mk(1, 5'b10000, 1, 0, 7, 1, B7, ALL, 16'd6, 0, 0);
    tbl[8]  = mk(1, 5'b10000, 1, 0, 7, 1, 0, ALL, 16'd6, 1, 0);
    tbl[9]  = mk(0, 5'b00001, 1, 0, 7, 0, B7, ALL, 16'd9, 1, 0);
    tbl[10] = mk(1, 5'b00001, 1, 0, 7, 1, B7, ALL, 16'd10, 1, 0);
    tbl[11] = mk(1, 5'b00010, 1, 0, 7, 1, 0, ALL, 16'd11, 1, 0);
    tbl[12] = mk(1, 5'b00100, 1, 0, 7, 1, 0, ALL, 16'd12, 0, 0);
    for (int i = 13; i < 16; i++) tbl[i] = mk(0, 5'b00001, 1, 0, 0, 0, B7, ALL, 16'(i), 1, 0);
    tbl[16] = mk(0, 5'b00001, 1, B7, 0, 0, B7, ALL, 16'd16, 1, 0);
    tbl[17] = mk(1, 5'b00001, 1, 0, 7, 1, 0, ALL, 16'd17, 1, 0);
    tbl[18] = mk(0, 5'b00001, 7, B7, 0, 0, B7, ALL, 16'd18, 0, 1);
    tbl[19] = mk(0, 5'b00001, 7, B7, 0, 0, 0, ALL, 16'd19, 1, 0);
    tbl[20] = mk(1, 5'b00001, 0, 32'h1, 0, 1, 0, ALL, 16'd20, 1, 0);
    tbl[21] = mk(1, 5'b00010, 0, 32'h1, 0, 1, 32'h1, ALL, 16'd21, 1, 0);
    tbl[22] = mk(0, 5'b00001, 0, '1, 0, 0, 0, ALL, 16'd22, 1, 0);
    tbl[23] = mk(1, 5'b00000, 1, 0, 0, 0, 0, ALL, 16'd23, 0, 0);
    tbl[24] = mk(1, 5'b00011, 1, 0, 0, 0, 0, ALL, 16'd24, 0, 0);
    tbl[25] = mk(1, 5'b10100, 1, 0, 0, 0, 0, ALL, 16'd25, 0, 0);
    tbl[26] = mk(1, 5'b00001, 1, 0, 0, 0, 0, 5'h1E, 16'd26, 1, 0);
    tbl[27] = mk(1, 5'b00010, 1, 0, 0, 0, 0, 5'h1E, 16'd27, 1, 0);
    tbl[28] = mk(1, 5'b00001, 1, 0, 0, 0, 0, 5'h1E, 16'd28, 0, 0);
    tbl[29] = mk(1, 5'b00001, 1, 0, 0, 0, 0, ALL, 16'd28, 1, 0);
    tbl[30] = mk(0, 5'b00001, 1, 0, 0, 0, 0, ALL, 16'd30, 1, 0);

    rst_core = 1'b1; flush_req = 1'b0; in_valid = 1'b0; in_select = 5'b00001;
    in_payload = '0; in_rs1_addr = '0; in_rs2_addr = '0; in_rs_mask = '0;
    in_rd_addr = '0; in_rd_we = 1'b0; rf_rs1_data = '0; rf_rs2_data = '0;
    commit_mask = '0; out_ready = '0;
    repeat (2) @(posedge clk_core);
    #1 rst_core = 1'b0;

    run(mk(0, 5'b00001, 3, '1, 0, 0, 0, ALL, 16'd0, 1, 0), "reset");
    for (int i = 0; i < 31; i++) run(tbl[i], $sformatf("vec%0d", i));

    t = mk(0, 5'b00001, 1, 0, 0, 0, 0, ALL, 16'd0, 0, 0);
    t.flush = 1'b1;
    run(t, "flush_pre_wrap");
    for (int i = 0; i < 17; i++)
      run(mk(1, 5'(1 << (i % 5)), 2, 0, 0, 0, 0, ALL, 16'(16'h100 + i), 1, 0), $sformatf("wrap%0d", i));
    run(mk(0, 5'b00001, 1, 0, 0, 0, 0, ALL, 16'd0, 1, 0), "wrap_drain");

    run(mk(1, 5'b00001, 1, 0, 3, 1, 0, 5'h00, 16'h200, 1, 0), "fl_a");
    run(mk(1, 5'b00010, 1, 0, 4, 1, 0, 5'h00, 16'h201, 1, 0), "fl_b");
    run(mk(1, 5'b00100, 1, 0, 5, 1, 0, 5'h00, 16'h202, 1, 0), "fl_c");
    run(mk(0, 5'b00001, 3, 32'h38, 0, 0, 0, 5'h00, 16'h0, 0, 1), "fl_hz");
    t = mk(1, 5'b01000, 1, 0, 6, 1, 0, 5'h00, 16'h203, 0, 1);
    t.mask = 32'h38; t.flush = 1'b1;
    run(t, "flush");
    run(mk(0, 5'b01000, 3, '1, 0, 0, 0, 5'h00, 16'h0, 1, 0), "post_flush");
    run(mk(1, 5'b00001, 3, 32'h38, 3, 1, 0, ALL, 16'h300, 1, 0), "post_flush_issue");
    run(mk(0, 5'b00001, 3, 0, 0, 0, 0, ALL, 16'h0, 1, 0), "final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
